// File: rtl/serializer_pkg.sv
// Shared types and defaults for the bit serializer.
package serializer_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
endpackage

// File: rtl/bit_serializer_if.sv
// Load/serial-stream bundle between a word producer and the serializer.
interface bit_serializer_if
  import serializer_pkg::*;
#(parameter int WIDTH = DEFAULT_WIDTH);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             advance;
  logic             out;
  logic             out_valid;
  logic             last;
  logic [7:0]       words_sent;

  modport master (output load_valid, load_data, advance,
                  input  load_ready, out, out_valid, last, words_sent);
  modport slave  (input  load_valid, load_data, advance,
                  output load_ready, out, out_valid, last, words_sent);
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter: one bit per advance strobe, back-to-back reload
// when the last bit is consumed and a new word is waiting.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic clk,
  input  logic rst,
  bit_serializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [7:0]       ws, ws_n;
  logic             done, accept;

  // done: final bit leaves on this edge
  assign done       = (state == SHIFT) && (cnt == '0) && bus.advance;
  assign bus.load_ready = !rst && ((state == IDLE) || done);
  assign accept     = bus.load_ready && bus.load_valid;

  assign bus.out_valid  = (state == SHIFT);
  assign bus.last       = (state == SHIFT) && (cnt == '0);
  assign bus.out        = (state == SHIFT) &&
                          (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
  assign bus.words_sent = ws;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      ws    <= '0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      cnt   <= cnt_n;
      ws    <= ws_n;
    end
  end

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    ws_n    = ws;
    if (state == SHIFT && bus.advance) begin
      shreg_n = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
      if (cnt != '0) cnt_n = cnt - 1'b1;
      if (done) begin
        ws_n    = ws + 8'd1;
        state_n = IDLE;
      end
    end
    // a reload overrides the shift/idle decision above
    if (accept) begin
      shreg_n = bus.load_data;
      cnt_n   = CW'(WIDTH - 1);
      state_n = SHIFT;
    end
  end
endmodule

// File: tb/tb_bit_serializer.sv
// Directed checks of bit_serializer: ordering, stalls, back-to-back, reset abort, wrap.
module tb_bit_serializer;
  logic clk = 1'b0;
  logic rst;
  int   vecs = 0;
  int   errs = 0;
  logic [7:0] pat;
  logic [7:0] ws_exp;

  always #5 clk = ~clk;

  bit_serializer_if #(.WIDTH(8)) bus_m ();
  bit_serializer_if #(.WIDTH(8)) bus_l ();

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bus_m.slave));
  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus_m.load_valid = 1'b1; bus_m.load_data = 8'hFF; bus_m.advance = 1'b1;
    bus_l.load_valid = 1'b0; bus_l.load_data = 8'h00; bus_l.advance = 1'b1;
    #1;
    chk("ready_in_reset", bus_m.load_ready, 1'b0);
    step(); step();
    chk("rst_out_valid", bus_m.out_valid, 1'b0);
    chk("rst_out", bus_m.out, 1'b0);
    chk("rst_last", bus_m.last, 1'b0);
    chk("rst_words", bus_m.words_sent, 8'd0);
    bus_m.load_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("idle_ready", bus_m.load_ready, 1'b1);
    ws_exp = 8'd0;

    // MSB-first B4
    bus_m.load_valid = 1'b1; bus_m.load_data = 8'hB4;
    step();
    bus_m.load_valid = 1'b0; bus_m.load_data = 8'h00;
    pat = 8'hB4;
    for (int i = 0; i < 8; i++) begin
      chk("b4_valid", bus_m.out_valid, 1'b1);
      chk("b4_out", bus_m.out, pat[7-i]);
      chk("b4_last", bus_m.last, (i == 7));
      chk("b4_ready", bus_m.load_ready, (i == 7));
      step();
    end
    ws_exp = ws_exp + 8'd1;
    chk("b4_idle", bus_m.out_valid, 1'b0);
    chk("b4_words", bus_m.words_sent, ws_exp);

    // LSB-first B4 on second instance
    bus_l.load_valid = 1'b1; bus_l.load_data = 8'hB4;
    step();
    bus_l.load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("lsb_out", bus_l.out, pat[i]);
      chk("lsb_last", bus_l.last, (i == 7));
      step();
    end
    chk("lsb_words", bus_l.words_sent, 8'd1);
    chk("lsb_idle", bus_l.out_valid, 1'b0);

    // back-to-back FF then 00
    bus_m.load_valid = 1'b1; bus_m.load_data = 8'hFF;
    step();
    bus_m.load_data = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) bus_m.load_valid = 1'b0;
      #1;
      chk("b2b_valid", bus_m.out_valid, 1'b1);
      chk("b2b_out", bus_m.out, (i < 8));
      chk("b2b_ready", bus_m.load_ready, (i == 7 || i == 15));
      step();
    end
    ws_exp = ws_exp + 8'd2;
    chk("b2b_idle", bus_m.out_valid, 1'b0);
    chk("b2b_words", bus_m.words_sent, ws_exp);

    // A5 with 3-cycle stall after bit 2
    bus_m.load_valid = 1'b1; bus_m.load_data = 8'hA5;
    step();
    bus_m.load_valid = 1'b0;
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      chk("a5_out", bus_m.out, pat[7-i]);
      chk("a5_last", bus_m.last, (i == 7));
      if (i == 1) begin
        bus_m.advance = 1'b0;
        #1;
        chk("stall_ready", bus_m.load_ready, 1'b0);
        for (int s = 0; s < 3; s++) begin
          step();
          chk("stall_out", bus_m.out, 1'b0);
          chk("stall_valid", bus_m.out_valid, 1'b1);
          chk("stall_last", bus_m.last, 1'b0);
        end
        bus_m.advance = 1'b1;
      end
      step();
    end
    ws_exp = ws_exp + 8'd1;
    chk("a5_words", bus_m.words_sent, ws_exp);
    chk("a5_idle", bus_m.last, 1'b0);

    // reset mid-word of C3, then 81 with a stalled last bit
    bus_m.load_valid = 1'b1; bus_m.load_data = 8'hC3;
    step();
    bus_m.load_valid = 1'b0;
    pat = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      chk("c3_out", bus_m.out, pat[7-i]);
      step();
    end
    rst = 1'b1;
    bus_m.load_valid = 1'b1; bus_m.load_data = 8'hFF;
    #1;
    chk("midrst_ready", bus_m.load_ready, 1'b0);
    step();
    rst = 1'b0;
    bus_m.load_valid = 1'b0;
    chk("abort_out", bus_m.out, 1'b0);
    chk("abort_valid", bus_m.out_valid, 1'b0);
    chk("abort_words", bus_m.words_sent, 8'd0);
    step();
    chk("abort_noresume", bus_m.out_valid, 1'b0);
    ws_exp = 8'd0;

    bus_m.load_valid = 1'b1; bus_m.load_data = 8'h81;
    step();
    bus_m.load_valid = 1'b0;
    pat = 8'h81;
    for (int i = 0; i < 8; i++) begin
      chk("x81_out", bus_m.out, pat[7-i]);
      if (i == 7) begin
        bus_m.advance = 1'b0;
        step();
        chk("x81_last_hold", bus_m.last, 1'b1);
        chk("x81_stall_words", bus_m.words_sent, ws_exp);
        bus_m.advance = 1'b1;
      end
      step();
    end
    ws_exp = ws_exp + 8'd1;
    chk("x81_words", bus_m.words_sent, ws_exp);

    // fill to 256 words back-to-back and check the wrap
    bus_m.load_valid = 1'b1; bus_m.load_data = 8'h00;
    step();
    for (int w = 0; w < 255; w++) begin
      for (int b = 0; b < 8; b++) begin
        if (w == 254 && b == 7) begin
          bus_m.load_valid = 1'b0;
          chk("pre_wrap", bus_m.words_sent, 8'd255);
        end
        step();
      end
    end
    chk("wrap_words", bus_m.words_sent, 8'd0);
    chk("wrap_idle", bus_m.out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
